dff_response_checker: RTL and testbench

- Synthesizable checker at the receiving end of a D flip-flop stimulus stream.
- Samples the stimulus bit driven into a flip-flop DUT and the DUT's Q/Q-prime outputs.
- Verifies that Q equals D delayed by LATENCY clocks and that Q-prime equals ~Q.
- Counts checked samples and errors, and reports PASS/FAIL, so flip-flop benches and on-board tests self-check without waveform inspection.

---
 rtl/dff_chk_defs_pkg.sv | 25 ++
 rtl/dff_chk_dly_line.sv | 39 +++
 rtl/dff_response_checker.sv | 166 ++++++++++++++++
 tb/tb_dff_response_checker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dff_chk_defs_pkg.sv
// dff_chk_defs: shared definitions for the D flip-flop response checker.
//   - chk_state_t : checker FSM state encodings
//   - LATENCY_MIN / LATENCY_MAX : legal range of the LATENCY parameter
//   - sat_inc     : saturating increment for counters up to 32 bits wide
package dff_chk_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } chk_state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;

  // Increment val, sticking at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/dff_chk_dly_line.sv
// dff_chk_dly_line: LATENCY-deep enabled shift register holding the recent
// stimulus bits. TAP is the bit shifted in LATENCY enabled edges ago.
// Ports:
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset (clears history)
//   CLR    synchronous clear of history
//   EN     shift enable; history holds while low
//   D      stimulus bit shifted into stage 0
//   TAP    oldest stage, hist[LATENCY-1]
module dff_chk_dly_line #(
  parameter int LATENCY = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLR,
  input  logic EN,
  input  logic D,
  output logic TAP
);

  logic [LATENCY-1:0] hist;

  // With LATENCY=1 the loop body never runs and hist is a single flop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist <= '0;
    end else if (CLR) begin
      hist <= '0;
    end else if (EN) begin
      hist[0] <= D;
      for (int i = 1; i < LATENCY; i++) begin
        hist[i] <= hist[i-1];
      end
    end
  end

  assign TAP = hist[LATENCY-1];

endmodule

// File: rtl/dff_response_checker.sv
// dff_response_checker: checks a flip-flop DUT against its own stimulus.
// Q_IN must equal D_IN delayed by LATENCY enabled clocks and QP_IN must equal
// ~Q_IN. Counts compared and mismatching samples and reports PASS / FAIL.
// Ports:
//   CLK, RST_N          clock (rising edge), async active-low reset
//   CLR                 synchronous clear of counters, history and state
//   EN                  run enable
//   STOP_ON_ERR         first mismatch moves to HALT when high
//   D_IN, Q_IN, QP_IN   stimulus bit and DUT Q / Q-prime
//   BUSY                state is FILL or CHECK
//   PASS, FAIL          verdict flags (never both high)
//   ERR_PULSE           one-cycle pulse per mismatching sample
//   CHK_CNT, ERR_CNT    saturating sample and error counters
// Optional (macro DFF_CHK_CAPTURE_EN):
//   FIRST_ERR_IDX, FIRST_ERR_EXP, FIRST_ERR_GOT  capture of the first mismatch
module dff_response_checker
  import dff_chk_defs::*;
#(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             EN,
  input  logic             STOP_ON_ERR,
  input  logic             D_IN,
  input  logic             Q_IN,
  input  logic             QP_IN,
  output logic             BUSY,
  output logic             PASS,
  output logic             FAIL,
  output logic             ERR_PULSE,
  output logic [CNT_W-1:0] CHK_CNT,
  output logic [CNT_W-1:0] ERR_CNT
`ifdef DFF_CHK_CAPTURE_EN
  ,
  output logic [CNT_W-1:0] FIRST_ERR_IDX,
  output logic             FIRST_ERR_EXP,
  output logic [1:0]       FIRST_ERR_GOT
`endif
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dff_response_checker: LATENCY out of range 1..8");
  end

  localparam logic [2:0] FILL_INIT = 3'(LATENCY - 1);

  chk_state_t       state;
  logic [2:0]       fill_cnt;
  logic             hist_tap;
  logic             shift_en;
  logic             do_cmp;
  logic             mismatch;
  logic [CNT_W-1:0] chk_nxt;
  logic [CNT_W-1:0] err_nxt;

  // History freezes in HALT so the failing context is preserved.
  assign shift_en = EN && (state != ST_HALT);
  assign do_cmp   = EN && (state == ST_CHECK);
  assign mismatch = (Q_IN != hist_tap) || (QP_IN == Q_IN);

  dff_chk_dly_line #(
    .LATENCY(LATENCY)
  ) u_dly_line (
    .CLK  (CLK),
    .RST_N(RST_N),
    .CLR  (CLR),
    .EN   (shift_en),
    .D    (D_IN),
    .TAP  (hist_tap)
  );

  always_comb begin
    chk_nxt = CHK_CNT;
    err_nxt = ERR_CNT;
    if (do_cmp) begin
      chk_nxt = CNT_W'(sat_inc(32'(CHK_CNT), CNT_W));
      if (mismatch) begin
        err_nxt = CNT_W'(sat_inc(32'(ERR_CNT), CNT_W));
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      fill_cnt  <= '0;
      BUSY      <= 1'b0;
      PASS      <= 1'b0;
      FAIL      <= 1'b0;
      ERR_PULSE <= 1'b0;
      CHK_CNT   <= '0;
      ERR_CNT   <= '0;
`ifdef DFF_CHK_CAPTURE_EN
      FIRST_ERR_IDX <= '0;
      FIRST_ERR_EXP <= 1'b0;
      FIRST_ERR_GOT <= 2'b00;
`endif
    end else if (CLR) begin
      state     <= ST_IDLE;
      fill_cnt  <= '0;
      BUSY      <= 1'b0;
      PASS      <= 1'b0;
      FAIL      <= 1'b0;
      ERR_PULSE <= 1'b0;
      CHK_CNT   <= '0;
      ERR_CNT   <= '0;
`ifdef DFF_CHK_CAPTURE_EN
      FIRST_ERR_IDX <= '0;
      FIRST_ERR_EXP <= 1'b0;
      FIRST_ERR_GOT <= 2'b00;
`endif
    end else begin
      CHK_CNT   <= chk_nxt;
      ERR_CNT   <= err_nxt;
      PASS      <= (chk_nxt != '0) && (err_nxt == '0);
      FAIL      <= (err_nxt != '0);
      ERR_PULSE <= do_cmp && mismatch;
`ifdef DFF_CHK_CAPTURE_EN
      // ERR_CNT saturates rather than wraps, so zero marks the first mismatch.
      if (do_cmp && mismatch && (ERR_CNT == '0)) begin
        FIRST_ERR_IDX <= chk_nxt;
        FIRST_ERR_EXP <= hist_tap;
        FIRST_ERR_GOT <= {Q_IN, QP_IN};
      end
`endif
      case (state)
        ST_IDLE: begin
          BUSY <= EN;
          if (EN) begin
            state    <= ST_FILL;
            fill_cnt <= FILL_INIT;
          end
        end
        // LATENCY enabled edges pass here so the history is fully refilled.
        ST_FILL: begin
          BUSY <= EN;
          if (!EN) begin
            state <= ST_IDLE;
          end else if (fill_cnt == 3'd0) begin
            state <= ST_CHECK;
          end else begin
            fill_cnt <= fill_cnt - 3'd1;
          end
        end
        ST_CHECK: begin
          if (!EN) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end else if (mismatch && STOP_ON_ERR) begin
            state <= ST_HALT;
            BUSY  <= 1'b0;
          end else begin
            BUSY  <= 1'b1;
          end
        end
        default: begin
          BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_response_checker.sv
// tb_dff_response_checker: directed bench for dff_response_checker.
// u_l1: LATENCY=1, CNT_W=16; u_l3: LATENCY=3 with a 3-flop chain;
// u_c4: LATENCY=1, CNT_W=4 for saturation and async reset.
module tb_dff_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic clr = 1'b0, en = 1'b0, stop = 1'b0, d = 1'b0;
  logic q_force0 = 1'b0, tie_eq = 1'b0;

  // Behavioural flip-flop DUTs
  logic ff1, ffa, ffb, ffc;
  always @(posedge clk) begin
    ff1 <= d;
    ffa <= d;
    ffb <= ffa;
    ffc <= ffb;
  end

  logic q1, qp1, qp3;
  assign q1  = ff1 & ~q_force0;
  assign qp1 = tie_eq ? q1 : ~q1;
  assign qp3 = ~ffc;

  logic        busy1, pass1, fail1, ep1;
  logic [15:0] chk1, err1;
  logic        busy3, pass3, fail3, ep3;
  logic [15:0] chk3, err3;
  logic        busy4, pass4, fail4, ep4;
  logic [3:0]  chk4, err4;

  dff_response_checker #(.LATENCY(1), .CNT_W(16)) u_l1 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .EN(en), .STOP_ON_ERR(stop),
    .D_IN(d), .Q_IN(q1), .QP_IN(qp1),
    .BUSY(busy1), .PASS(pass1), .FAIL(fail1), .ERR_PULSE(ep1),
    .CHK_CNT(chk1), .ERR_CNT(err1)
  );

  dff_response_checker #(.LATENCY(3), .CNT_W(16)) u_l3 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .EN(en), .STOP_ON_ERR(stop),
    .D_IN(d), .Q_IN(ffc), .QP_IN(qp3),
    .BUSY(busy3), .PASS(pass3), .FAIL(fail3), .ERR_PULSE(ep3),
    .CHK_CNT(chk3), .ERR_CNT(err3)
  );

  dff_response_checker #(.LATENCY(1), .CNT_W(4)) u_c4 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .EN(en), .STOP_ON_ERR(stop),
    .D_IN(d), .Q_IN(q1), .QP_IN(qp1),
    .BUSY(busy4), .PASS(pass4), .FAIL(fail4), .ERR_PULSE(ep4),
    .CHK_CNT(chk4), .ERR_CNT(err4)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pat = 32'hB5C3_9A61;
  int          k   = 0;

  task automatic tick_d();
    d = pat[k % 32];
    k++;
    tick();
  endtask

  initial begin
    // Reset state, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy1), 32'd0);
    check_eq("rst_pass", 32'(pass1), 32'd0);
    check_eq("rst_fail", 32'(fail1), 32'd0);
    check_eq("rst_chk",  32'(chk1),  32'd0);
    check_eq("rst_err",  32'(err1),  32'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Ideal DFF, LATENCY=1, D = 0,1,1,0,1
    d = 1'b0; en = 1'b1;
    tick();
    check_eq("t1_busy_fill", 32'(busy1), 32'd1);
    check_eq("t1_chk_fill",  32'(chk1),  32'd0);
    d = 1'b1; tick();
    check_eq("t1_chk_pre",  32'(chk1),  32'd0);
    check_eq("t1_pass_pre", 32'(pass1), 32'd0);
    d = 1'b1; tick();
    check_eq("t1_chk_1",  32'(chk1),  32'd1);
    check_eq("t1_pass_1", 32'(pass1), 32'd1);
    check_eq("t1_fail_1", 32'(fail1), 32'd0);
    d = 1'b0; tick();
    check_eq("t1_chk_2", 32'(chk1), 32'd2);
    d = 1'b1; tick();
    check_eq("t1_chk_3",  32'(chk1),  32'd3);
    check_eq("t1_err_3",  32'(err1),  32'd0);
    check_eq("t1_pass_3", 32'(pass1), 32'd1);

    // Single forced-low Q while the expected bit is 1
    clr = 1'b1; tick(); clr = 1'b0;
    check_eq("t2_clr_chk",  32'(chk1),  32'd0);
    check_eq("t2_clr_busy", 32'(busy1), 32'd0);
    check_eq("t2_clr_pass", 32'(pass1), 32'd0);
    d = 1'b1;
    repeat (3) tick();
    check_eq("t2_chk_1",  32'(chk1),  32'd1);
    check_eq("t2_pass_1", 32'(pass1), 32'd1);
    q_force0 = 1'b1; tick(); q_force0 = 1'b0;
    check_eq("t2_pulse", 32'(ep1),   32'd1);
    check_eq("t2_err",   32'(err1),  32'd1);
    check_eq("t2_fail",  32'(fail1), 32'd1);
    check_eq("t2_pass",  32'(pass1), 32'd0);
    check_eq("t2_chk_2", 32'(chk1),  32'd2);
    tick();
    check_eq("t2_pulse_off", 32'(ep1),  32'd0);
    check_eq("t2_chk_3",     32'(chk1), 32'd3);
    check_eq("t2_err_hold",  32'(err1), 32'd1);

    // QP tied to Q with STOP_ON_ERR: halt on the first compare
    clr = 1'b1; stop = 1'b1; tie_eq = 1'b1; tick(); clr = 1'b0;
    repeat (3) tick();
    check_eq("t3_chk",   32'(chk1),  32'd1);
    check_eq("t3_err",   32'(err1),  32'd1);
    check_eq("t3_fail",  32'(fail1), 32'd1);
    check_eq("t3_busy",  32'(busy1), 32'd0);
    check_eq("t3_pulse", 32'(ep1),   32'd1);
    en = 1'b0; tick(); en = 1'b1; tick(); tick();
    check_eq("t3_chk_frozen", 32'(chk1),  32'd1);
    check_eq("t3_err_frozen", 32'(err1),  32'd1);
    check_eq("t3_busy_halt",  32'(busy1), 32'd0);
    check_eq("t3_pulse_off",  32'(ep1),   32'd0);
    clr = 1'b1; tick(); clr = 1'b0;
    check_eq("t3_clr_chk",  32'(chk1),  32'd0);
    check_eq("t3_clr_err",  32'(err1),  32'd0);
    check_eq("t3_clr_fail", 32'(fail1), 32'd0);
    stop = 1'b0; tie_eq = 1'b0;

    // LATENCY=3 with 3-flop chain and a 4-cycle enable gap
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (4) tick_d();
    check_eq("t4_busy_fill", 32'(busy3), 32'd1);
    check_eq("t4_chk_fill",  32'(chk3),  32'd0);
    tick_d();
    check_eq("t4_chk_1", 32'(chk3), 32'd1);
    repeat (3) tick_d();
    check_eq("t4_chk_4", 32'(chk3), 32'd4);
    en = 1'b0;
    tick_d();
    check_eq("t4_gap_busy", 32'(busy3), 32'd0);
    repeat (3) tick_d();
    check_eq("t4_gap_busy_end", 32'(busy3), 32'd0);
    check_eq("t4_gap_chk",      32'(chk3),  32'd4);
    en = 1'b1;
    repeat (4) tick_d();
    check_eq("t4_refill_chk",  32'(chk3),  32'd4);
    check_eq("t4_refill_busy", 32'(busy3), 32'd1);
    tick_d();
    check_eq("t4_resume_chk", 32'(chk3), 32'd5);
    repeat (3) tick_d();
    check_eq("t4_chk_8", 32'(chk3),  32'd8);
    check_eq("t4_err",   32'(err3),  32'd0);
    check_eq("t4_pass",  32'(pass3), 32'd1);

    // CNT_W=4 saturation, CLR, then asynchronous reset mid-CHECK
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (2) tick_d();
    repeat (20) tick_d();
    check_eq("t5_chk_sat", 32'(chk4),  32'd15);
    check_eq("t5_err",     32'(err4),  32'd0);
    check_eq("t5_pass",    32'(pass4), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    check_eq("t5_clr_chk",  32'(chk4),  32'd0);
    check_eq("t5_clr_pass", 32'(pass4), 32'd0);
    check_eq("t5_clr_busy", 32'(busy4), 32'd0);
    repeat (5) tick_d();
    check_eq("t5_chk_3",  32'(chk4),  32'd3);
    check_eq("t5_busy_3", 32'(busy4), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_arst_chk",  32'(chk4),  32'd0);
    check_eq("t5_arst_busy", 32'(busy4), 32'd0);
    check_eq("t5_arst_pass", 32'(pass4), 32'd0);
    check_eq("t5_arst_chk1", 32'(chk1),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
